// File: rtl/mlp_forward_if.sv
// Pass-control handshake for mlp_forward: request/train qualifiers in, status pulses out.
interface mlp_forward_if;
    logic start;
    logic train_en;
    logic busy;
    logic done;
    logic learn;

    modport master (output start, output train_en, input busy, input done, input learn);
    modport slave  (input start, input train_en, output busy, output done, output learn);
endinterface

// File: rtl/mlp_forward.sv
// 16-input, N-hidden-neuron, single-output MLP forward pass; one hidden neuron per
// cycle, then one output MAC per cycle, then saturating output/error stage.
module mlp_forward #(
    parameter int W    = 8,
    parameter int N    = 8,
    parameter int FRAC = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mlp_forward_if.slave              ctl,
    input  logic [15:0]               x,
    input  logic signed [W-1:0]       target,
    input  logic signed [N*16*W-1:0]  w_h_bus,
    input  logic signed [N*W-1:0]     b_h_bus,
    input  logic signed [N*W-1:0]     w_o_bus,
    input  logic signed [W-1:0]       b_o_in,
    output logic signed [N*(W+5)-1:0] h_act_bus,
    output logic signed [W-1:0]       y_out,
    output logic signed [W-1:0]       err,
    output logic                      pred
);
    localparam int HW = W + 5;
    localparam int AW = 2 * W + 8;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [AW:0]  YMAX = (AW + 1)'((1 <<< (W - 1)) - 1);
    localparam logic signed [AW:0]  YMIN = -YMAX - 1;
    localparam logic signed [W+1:0] EMAX = (W + 2)'((1 <<< (W - 1)) - 1);
    localparam logic signed [W+1:0] EMIN = -EMAX - 1;

    typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_FIN} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [15:0]           r_x;
    logic signed [W-1:0]   r_target;
    logic                  r_train;
    logic signed [AW-1:0]  r_acc;
    logic signed [HW-1:0]  r_h_act [N];
    logic                  r_busy;
    logic                  r_done;
    logic                  r_learn;

    logic signed [HW-1:0]  w_raw;
    logic signed [HW-1:0]  w_term;
    logic signed [AW-1:0]  w_prod;
    logic signed [AW-1:0]  w_shift;
    logic signed [AW:0]    w_ysum;
    logic signed [W-1:0]   w_y;
    logic signed [W+1:0]   w_ediff;
    logic signed [W-1:0]   w_err;
    logic                  w_last;

    assign w_last = (r_cnt == CW'(N - 1));

    // 16 terms plus bias of W bits each stay within W+5 bits, so no overflow handling.
    always_comb begin
        w_term = '0;
        w_raw  = HW'($signed(b_h_bus[r_cnt*W +: W]));
        for (int unsigned j = 0; j < 16; j++) begin
            w_term = HW'($signed(w_h_bus[(r_cnt*16 + j)*W +: W]));
            w_raw  = r_x[j] ? (w_raw + w_term) : (w_raw - w_term);
        end
    end

    assign w_prod = AW'($signed(w_o_bus[r_cnt*W +: W])) * AW'(r_h_act[r_cnt]);

    always_comb begin
        w_shift = r_acc >>> FRAC;
        w_ysum  = (AW + 1)'(b_o_in) + (AW + 1)'(w_shift);
        if (w_ysum > YMAX)
            w_y = W'(YMAX);
        else if (w_ysum < YMIN)
            w_y = W'(YMIN);
        else
            w_y = W'(w_ysum);
        w_ediff = (W + 2)'(r_target) - (W + 2)'(w_y);
        if (w_ediff > EMAX)
            w_err = W'(EMAX);
        else if (w_ediff < EMIN)
            w_err = W'(EMIN);
        else
            w_err = W'(w_ediff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_target <= '0;
            r_train  <= 1'b0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_learn  <= 1'b0;
            y_out    <= '0;
            err      <= '0;
            pred     <= 1'b0;
            for (int unsigned i = 0; i < N; i++)
                r_h_act[i] <= '0;
        end else begin
            r_done  <= 1'b0;
            r_learn <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctl.start) begin
                        r_x      <= x;
                        r_target <= target;
                        r_train  <= ctl.train_en;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_HID;
                    end
                end
                S_HID: begin
                    r_h_act[r_cnt] <= (w_raw > 0) ? w_raw : '0;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    r_acc <= r_acc + w_prod;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    y_out   <= w_y;
                    err     <= w_err;
                    pred    <= (w_y > 0);
                    r_done  <= 1'b1;
                    r_learn <= r_train;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ctl.busy  = r_busy;
    assign ctl.done  = r_done;
    assign ctl.learn = r_learn;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign h_act_bus[g*HW +: HW] = r_h_act[g];
    end
endmodule

// File: tb/tb_mlp_forward.sv
// Directed and randomized forward passes checked against an integer reference model.
module tb_mlp_forward;
    localparam int W    = 8;
    localparam int N    = 8;
    localparam int FRAC = 6;
    localparam int HW   = W + 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mlp_forward_if ctl ();

    logic [15:0]               x;
    logic signed [W-1:0]       target;
    logic signed [N*16*W-1:0]  w_h_bus;
    logic signed [N*W-1:0]     b_h_bus;
    logic signed [N*W-1:0]     w_o_bus;
    logic signed [W-1:0]       b_o_in;
    logic signed [N*HW-1:0]    h_act_bus;
    logic signed [W-1:0]       y_out;
    logic signed [W-1:0]       err;
    logic                      pred;

    mlp_forward #(.W(W), .N(N), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctl       (ctl),
        .x         (x),
        .target    (target),
        .w_h_bus   (w_h_bus),
        .b_h_bus   (b_h_bus),
        .w_o_bus   (w_o_bus),
        .b_o_in    (b_o_in),
        .h_act_bus (h_act_bus),
        .y_out     (y_out),
        .err       (err),
        .pred      (pred)
    );

    int wh [N][16];
    int bh [N];
    int wo [N];
    int bo;
    int exp_h [N];
    int exp_y, exp_err, exp_pred;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pack_buses();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 16; j++)
                w_h_bus[(i*16 + j)*W +: W] = W'(wh[i][j]);
            b_h_bus[i*W +: W] = W'(bh[i]);
            w_o_bus[i*W +: W] = W'(wo[i]);
        end
        b_o_in = W'(bo);
    endtask

    function automatic int clamp(input longint v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    task automatic model(input logic [15:0] xv, input int tgt);
        longint acc, q;
        int raw;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            raw = bh[i];
            for (int j = 0; j < 16; j++)
                raw += xv[j] ? wh[i][j] : -wh[i][j];
            exp_h[i] = (raw > 0) ? raw : 0;
            acc += longint'(wo[i]) * longint'(exp_h[i]);
        end
        q = acc / (64'sd1 <<< FRAC);
        if (acc < 0 && (acc % (64'sd1 <<< FRAC)) != 0)
            q -= 1;
        exp_y    = clamp(longint'(bo) + q);
        exp_err  = clamp(longint'(tgt) - longint'(exp_y));
        exp_pred = (exp_y > 0) ? 1 : 0;
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_h%0d", tag, i), $signed(h_act_bus[i*HW +: HW]), exp_h[i]);
        check({tag, "_y"}, y_out, exp_y);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_pred"}, pred, exp_pred);
    endtask

    task automatic rand_weights();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 16; j++)
                wh[i][j] = int'($urandom_range(255)) - 128;
            bh[i] = int'($urandom_range(255)) - 128;
            wo[i] = int'($urandom_range(255)) - 128;
        end
        bo = int'($urandom_range(255)) - 128;
        pack_buses();
    endtask

    task automatic set_weights(input int vwh, input int vbh, input int vwo, input int vbo);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 16; j++)
                wh[i][j] = vwh;
            bh[i] = vbh;
            wo[i] = vwo;
        end
        bo = vbo;
        pack_buses();
    endtask

    // Called at a negedge; returns at the negedge following the done cycle.
    task automatic run_pass(input string tag, input logic [15:0] xv, input int tgt, input bit tr, input bit disturb);
        int cyc;
        model(xv, tgt);
        x = xv;
        target = W'(tgt);
        ctl.train_en = tr;
        ctl.start = 1'b1;
        @(negedge clk);
        ctl.start = 1'b0;
        check({tag, "_busy_start"}, ctl.busy, 1);
        if (disturb) begin
            x = ~xv;
            target = W'($urandom_range(255));
            ctl.train_en = ~tr;
        end
        cyc = 0;
        while (!ctl.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1)
                check({tag, "_h0_early"}, $signed(h_act_bus[0 +: HW]), exp_h[0]);
            if (disturb && cyc == 5) ctl.start = 1'b1;
            if (disturb && cyc == 6) ctl.start = 1'b0;
        end
        check({tag, "_latency"}, cyc, 2*N + 1);
        check({tag, "_busy_done"}, ctl.busy, 0);
        check({tag, "_learn"}, ctl.learn, tr);
        check_results(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, ctl.done, 0);
        check({tag, "_learn_pulse"}, ctl.learn, 0);
        check({tag, "_idle"}, ctl.busy, 0);
    endtask

    initial begin
        int cyc, seen;
        logic [15:0] xr;
        rst_n = 1'b0;
        ctl.start = 1'b0;
        ctl.train_en = 1'b0;
        x = '0;
        target = '0;
        set_weights(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_busy", ctl.busy, 0);
        check("rst_done", ctl.done, 0);
        check("rst_learn", ctl.learn, 0);
        check("rst_hbus", h_act_bus, 0);
        check("rst_y", y_out, 0);
        check("rst_err", err, 0);
        check("rst_pred", pred, 0);
        rst_n = 1'b1;

        set_weights(0, 0, 0, 0);
        run_pass("zero", 16'hA5A5, 64, 1'b1, 1'b0);
        set_weights(1, 0, 64, 0);
        run_pass("sat", 16'hFFFF, 0, 1'b1, 1'b0);
        set_weights(1, 0, 64, -5);
        run_pass("neg", 16'h0000, -128, 1'b1, 1'b0);
        set_weights(1, 0, 64, 0);
        run_pass("errsat", 16'hFFFF, -128, 1'b0, 1'b0);

        for (int p = 0; p < 12; p++) begin
            rand_weights();
            xr = 16'($urandom);
            run_pass($sformatf("rnd%0d", p), xr, int'($urandom_range(255)) - 128,
                     1'($urandom_range(1)), 1'(p % 2));
        end

        // Mid-pass reset: previous outputs are nonzero-capable, reset must clear them.
        set_weights(1, 0, 64, 0);
        run_pass("pre_rst", 16'hFFFF, 0, 1'b1, 1'b0);
        set_weights(2, 1, 5, 3);
        x = 16'h1234;
        target = 8'sd10;
        ctl.train_en = 1'b1;
        ctl.start = 1'b1;
        @(negedge clk);
        ctl.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_busy", ctl.busy, 0);
        check("mrst_done", ctl.done, 0);
        check("mrst_learn", ctl.learn, 0);
        check("mrst_hbus", h_act_bus, 0);
        check("mrst_y", y_out, 0);
        check("mrst_err", err, 0);
        check("mrst_pred", pred, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ctl.done || ctl.learn) seen++;
        end
        check("mrst_no_done", seen, 0);
        rst_n = 1'b1;
        rand_weights();
        run_pass("post_rst", 16'hC3A1, -77, 1'b1, 1'b0);

        // Start held high: passes repeat every 2N+2 edges.
        rand_weights();
        xr = 16'h5A0F;
        model(xr, 33);
        x = xr;
        target = 8'sd33;
        ctl.train_en = 1'b1;
        ctl.start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!ctl.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first", cyc, 2*N + 1);
        check_results("b2b0");
        for (int r = 1; r <= 2; r++) begin
            if (r == 2) ctl.start = 1'b1;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!ctl.done && cyc < 40);
            check($sformatf("b2b_period%0d", r), cyc, 2*N + 2);
            check($sformatf("b2b_learn%0d", r), ctl.learn, 1);
            check_results($sformatf("b2b%0d", r));
        end
        ctl.start = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (ctl.done || ctl.busy) seen++;
        end
        check("b2b_stop", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mlp_forward.md
MLP_FORWARD -- requirements
Module: mlp_forward

Interface
REQ-001 Parameter W, default 8: signed weight/error width.
REQ-002 Parameter N, default 8: number of hidden neurons.
REQ-003 Parameter FRAC, default 6: fractional bits of output-layer weights.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request one forward pass; accepted only in IDLE.
REQ-007 train_en  input  1  when 1, completion also pulses learn.
REQ-008 x  input  16  binary 4x4 pixel vector; bit j=1 means +1, 0 means -1.
REQ-009 target  input  signed W  desired output, e.g. +64 for O, -64 for X.
REQ-010 w_h_bus  input  signed N*16*W  hidden weights; neuron i, input j at [(i*16+j)*W +: W].
REQ-011 b_h_bus  input  signed N*W  hidden biases; neuron i at [i*W +: W].
REQ-012 w_o_bus  input  signed N*W  output weights; neuron i at [i*W +: W].
REQ-013 b_o_in  input  signed W  output bias.
REQ-014 busy  output  1  pass in progress.
REQ-015 done  output  1  one-cycle pulse: results valid.
REQ-016 learn  output  1  one-cycle pulse coincident with done when train_en was 1 at start.
REQ-017 h_act_bus  output  signed N*(W+5)  ReLU hidden activations; neuron i at [i*(W+5) +: W+5].
REQ-018 y_out  output  signed W  network output.
REQ-019 err  output  signed W  target minus y_out, saturated.
REQ-020 pred  output  1  1 when y_out > 0 (O detected).

Function
REQ-021 FSM states IDLE, HID, OUT, FIN; IDLE->HID on start, HID->OUT after N cycles, OUT->FIN after N cycles, FIN->IDLE after one cycle.
REQ-022 At start acceptance, x, target, train_en are latched; later input changes do not affect the pass.
REQ-023 Weight/bias buses are sampled live during HID/OUT; they are stable between learn pulses.
REQ-024 HID cycle k (k=0..N-1): raw_k = b_h[k] + sum over j of (x[j] ? +w_h[k][j] : -w_h[k][j]), computed at W+5 bits (range fits, no overflow).
REQ-025 h_act[k] = raw_k if raw_k > 0 else 0; written to h_act_bus slice k at end of HID cycle k.
REQ-026 OUT cycle k: acc += w_o[k] * h_act[k]; acc is 2W+8 bits signed, cleared on start acceptance.
REQ-027 FIN: y = b_o_in + (acc >>> FRAC), saturated to [-128,127] (general W: signed W-bit range); registered into y_out.
REQ-028 FIN: err = target - y_out value computed in FIN, computed at W+2 bits then saturated to signed W; pred = (y > 0).
REQ-029 done, and learn if latched train_en=1, are high exactly the one cycle after the FIN edge; busy low in that same cycle.
REQ-030 Latency: start sampled at edge t -> done high after edge t+2N+1 (17 edges for N=8).
REQ-031 busy high from edge after start acceptance through the FIN edge.
REQ-032 start while busy or in the done cycle's FIN->IDLE transition edge is ignored; start in the done cycle (state IDLE) is accepted.
REQ-033 h_act_bus, y_out, err, pred hold their values until overwritten by the next pass; h_act slices update progressively during HID.

Reset
REQ-034 rst_n=0 at any edge, including mid-pass: state IDLE, busy=0, done=0, learn=0, h_act_bus=0, y_out=0, err=0, pred=0, acc=0, latched x/target/train_en=0.
REQ-035 Reset aborts a pass without emitting done or learn; start in the first cycle after reset is accepted.

Verification
REQ-036 All weights/biases 0, x=16'hA5A5, target=64, train_en=1 -> done and learn 17 edges after start, h_act all 0, y_out=0, err=64, pred=0.
REQ-037 w_h all +1, b_h 0, w_o all 64, b_o 0, x=16'hFFFF, target=0 -> each h_act=16, acc=8192, y_out=127 (saturated), err=-127, pred=1.
REQ-038 Same weights, x=16'h0000 -> each raw=-16, h_act all 0, y_out=0; with b_o_in=-5, target=-128 -> y_out=-5, err=-123.
REQ-039 Err saturation: force y_out=127 (REQ-037 setup), target=-128 -> err=-128; train_en=0 -> done pulses, learn stays 0.
REQ-040 start held high continuously -> passes back-to-back, one done per 18 edges; start pulses during busy ignored; rst_n low at HID cycle 3 -> no done, all outputs 0.
